// File: rtl/stv_cart_rom_fetch.sv
// Two-entry 64-bit line buffer between the STV cart block's 16-bit ROM reads
// and the external 64-bit ROM port, with optional sequential next-line prefetch.
module stv_cart_rom_fetch (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INV,
  input  logic        PF_EN,
  input  logic [25:1] REQ_A,
  input  logic        REQ_RD,
  output logic [15:0] REQ_DO,
  output logic        REQ_RDY,
  output logic [25:3] DDR_ADDR,
  output logic        DDR_RD,
  input  logic        DDR_BUSY,
  input  logic [63:0] DDR_DI,
  input  logic        DDR_RDY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DFETCH,
    S_DWAIT,
    S_PFETCH,
    S_PWAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        rd_old_q;
  logic [1:0]  vld_q, vld_d;
  logic [25:3] tag_q [0:1];
  logic [25:3] tag_d [0:1];
  logic [63:0] data_q [0:1];
  logic [1:0]  wr_en;
  logic        mru_q, mru_d;
  logic        tgt_q, tgt_d;
  logic [25:1] pend_a_q, pend_a_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] do_q, do_d;
  logic [25:3] addr_q, addr_d;

  logic        new_req;
  logic        lookup;
  logic [1:0]  vld_eff;
  logic [25:1] lk_a;
  logic        hit0, hit1;
  logic [25:3] next_line;
  logic        next_cached;

  function automatic logic [15:0] sel_word(input logic [63:0] line,
                                           input logic [1:0]  k);
    logic [15:0] w;
    case (k)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  // Only a rising edge of REQ_RD starts a transaction.
  assign new_req = REQ_RD & ~rd_old_q;
  assign vld_eff = vld_q & {2{~INV}};

  // A request parked during a prefetch takes precedence over the live port.
  assign lk_a = pend_vld_q ? pend_a_q : REQ_A;
  assign hit0 = vld_eff[0] && (tag_q[0] == lk_a[25:3]);
  assign hit1 = vld_eff[1] && (tag_q[1] == lk_a[25:3]);

  assign next_line   = pend_a_q[25:3] + 23'd1;
  assign next_cached = (vld_eff[0] && (tag_q[0] == next_line)) ||
                       (vld_eff[1] && (tag_q[1] == next_line));

  assign REQ_RDY  = (state_q == S_RESP);
  assign REQ_DO   = do_q;
  assign DDR_ADDR = addr_q;

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_eff;
    tag_d      = tag_q;
    wr_en      = 2'b00;
    mru_d      = mru_q;
    tgt_d      = tgt_q;
    pend_a_d   = pend_a_q;
    pend_vld_d = pend_vld_q;
    do_d       = do_q;
    addr_d     = addr_q;
    DDR_RD     = 1'b0;
    lookup     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q || new_req) lookup = 1'b1;
      end

      S_DFETCH: begin
        if (!DDR_BUSY) begin
          DDR_RD  = 1'b1;
          state_d = S_DWAIT;
        end
      end

      S_DWAIT: begin
        if (DDR_RDY) begin
          wr_en[tgt_q] = 1'b1;
          tag_d[tgt_q] = addr_q;
          vld_d[tgt_q] = ~INV;
          do_d         = sel_word(DDR_DI, pend_a_q[2:1]);
          mru_d        = tgt_q;
          state_d      = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        if (PF_EN && !INV && !next_cached) begin
          addr_d  = next_line;
          tgt_d   = ~mru_q;
          state_d = S_PFETCH;
        end
      end

      // A demand edge before the strobe goes out cancels the prefetch.
      S_PFETCH: begin
        if (new_req) begin
          lookup = 1'b1;
        end else if (INV) begin
          state_d = S_IDLE;
        end else if (!DDR_BUSY) begin
          DDR_RD  = 1'b1;
          state_d = S_PWAIT;
        end
      end

      S_PWAIT: begin
        if (new_req) begin
          pend_a_d   = REQ_A;
          pend_vld_d = 1'b1;
        end
        if (DDR_RDY) begin
          wr_en[tgt_q] = 1'b1;
          tag_d[tgt_q] = addr_q;
          vld_d[tgt_q] = ~INV;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (lookup) begin
      pend_vld_d = 1'b0;
      pend_a_d   = lk_a;
      if (hit0 || hit1) begin
        do_d    = hit0 ? sel_word(data_q[0], lk_a[2:1])
                       : sel_word(data_q[1], lk_a[2:1]);
        mru_d   = hit1;
        state_d = S_RESP;
      end else begin
        tgt_d   = ~mru_q;
        addr_d  = lk_a[25:3];
        state_d = S_DFETCH;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      rd_old_q   <= 1'b0;
      vld_q      <= 2'b00;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      mru_q      <= 1'b0;
      tgt_q      <= 1'b0;
      pend_a_q   <= '0;
      pend_vld_q <= 1'b0;
      do_q       <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_old_q   <= REQ_RD;
      vld_q      <= vld_d;
      tag_q[0]   <= tag_d[0];
      tag_q[1]   <= tag_d[1];
      mru_q      <= mru_d;
      tgt_q      <= tgt_d;
      pend_a_q   <= pend_a_d;
      pend_vld_q <= pend_vld_d;
      do_q       <= do_d;
      addr_q     <= addr_d;
    end
  end

  // Line storage carries no reset; the valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (wr_en[0]) data_q[0] <= DDR_DI;
    if (wr_en[1]) data_q[1] <= DDR_DI;
  end

endmodule

// File: tb/tb_stv_cart_rom_fetch.sv
// Directed bench for stv_cart_rom_fetch: a fixed-latency ROM responder plus
// hand-computed request vectors covering hits, misses, prefetch, wrap, INV, busy and reset.
module tb_stv_cart_rom_fetch;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        INV;
  logic        PF_EN;
  logic [25:1] REQ_A;
  logic        REQ_RD;
  logic [15:0] REQ_DO;
  logic        REQ_RDY;
  logic [25:3] DDR_ADDR;
  logic        DDR_RD;
  logic        DDR_BUSY;
  logic [63:0] DDR_DI;
  logic        DDR_RDY;

  stv_cart_rom_fetch dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .INV      (INV),
    .PF_EN    (PF_EN),
    .REQ_A    (REQ_A),
    .REQ_RD   (REQ_RD),
    .REQ_DO   (REQ_DO),
    .REQ_RDY  (REQ_RDY),
    .DDR_ADDR (DDR_ADDR),
    .DDR_RD   (DDR_RD),
    .DDR_BUSY (DDR_BUSY),
    .DDR_DI   (DDR_DI),
    .DDR_RDY  (DDR_RDY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          ddr_lat     = 3;
  int          rd_cnt      = 0;
  int          rdy_cnt     = 0;
  int          busy_viol   = 0;
  int          dbl_viol    = 0;
  int          ddr_rd_cyc  = 0;
  int          ddr_rdy_cyc = 0;
  int          req_rdy_cyc = 0;
  logic [22:0] last_addr   = '0;

  // Line k of the ROM: word j = {line[13:0], j}; line 2 carries the reference pattern.
  function automatic logic [63:0] ddr_line(input logic [22:0] ln);
    logic [13:0] l;
    l = ln[13:0];
    if (ln == 23'h2) return 64'h4444_3333_2222_1111;
    return {l, 2'd3, l, 2'd2, l, 2'd1, l, 2'd0};
  endfunction

  initial begin
    DDR_RDY = 1'b0;
    DDR_DI  = '0;
    forever begin
      @(negedge CLK);
      if (DDR_RD === 1'b1) begin
        rd_cnt++;
        ddr_rd_cyc = cyc;
        last_addr  = DDR_ADDR;
        @(posedge CLK);
        repeat (ddr_lat - 1) @(posedge CLK);
        #1;
        DDR_DI  = ddr_line(last_addr);
        DDR_RDY = 1'b1;
        @(posedge CLK);
        #1 DDR_RDY = 1'b0;
      end
    end
  end

  initial begin
    bit prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge CLK);
      if (REQ_RDY === 1'b1) begin
        rdy_cnt++;
        req_rdy_cyc = cyc;
        if (prev_rdy) dbl_viol++;
      end
      if (DDR_RDY === 1'b1) ddr_rdy_cyc = cyc;
      if (DDR_RD === 1'b1 && DDR_BUSY === 1'b1) busy_viol++;
      prev_rdy = (REQ_RDY === 1'b1);
    end
  end

  task automatic do_req(input logic [25:0] ba, output logic [15:0] data,
                        output int lat, output int start, output int rds);
    int n;
    REQ_A  = ba[25:1];
    REQ_RD = 1'b1;
    start  = cyc;
    n      = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (REQ_RDY !== 1'b1 && n < 300);
    if (REQ_RDY !== 1'b1) chk("req_timeout", REQ_RDY, 1);
    data = REQ_DO;
    lat  = cyc - start;
    rds  = rd_cnt;
    @(posedge CLK);
    #1 REQ_RD = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_strobe(input int base);
    int n;
    n = 0;
    while (rd_cnt == base && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (rd_cnt == base) chk("strobe_timeout", rd_cnt, base + 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic inv_pulse();
    @(posedge CLK);
    #1 INV = 1'b1;
    @(posedge CLK);
    #1 INV = 1'b0;
  endtask

  logic [15:0] d;
  int          lat, st, rds, b, r0;

  initial begin
    RST_N    = 1'b0;
    INV      = 1'b0;
    PF_EN    = 1'b0;
    REQ_A    = '0;
    REQ_RD   = 1'b0;
    DDR_BUSY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rdy", REQ_RDY, 0);
    chk("rst_ddr_rd", DDR_RD, 0);
    chk("rst_do", REQ_DO, 0);
    chk("rst_addr", DDR_ADDR, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    settle(1);

    // cold miss on line 2
    ddr_lat = 3;
    b = rd_cnt;
    do_req(26'h10, d, lat, st, rds);
    chk("cold_addr", last_addr, 23'h2);
    chk("cold_do", d, 16'h1111);
    chk("cold_strobe_lat", ddr_rd_cyc - st, 1);
    chk("cold_rdy_lat", req_rdy_cyc - ddr_rdy_cyc, 1);
    chk("cold_nrd", rds - b, 1);

    // hit in the freshly filled line
    b = rd_cnt;
    do_req(26'h16, d, lat, st, rds);
    chk("hit_do", d, 16'h4444);
    chk("hit_lat", lat, 1);
    chk("hit_nrd", rds - b, 0);

    // prefetch of line 3, demand for it arrives during the fill
    PF_EN = 1'b1;
    inv_pulse();
    ddr_lat = 6;
    b = rd_cnt;
    do_req(26'h10, d, lat, st, rds);
    chk("pf_cold_do", d, 16'h1111);
    chk("pf_addr", last_addr, 23'h3);
    do_req(26'h18, d, lat, st, rds);
    chk("pf_hit_do", d, 16'h000C);
    chk("pf_lat", lat, 7);
    chk("pf_rdy_gap", req_rdy_cyc - ddr_rdy_cyc, 2);
    chk("pf_nrd", rds - b, 2);
    settle(20);

    // wrap of the prefetch line address
    inv_pulse();
    ddr_lat = 3;
    do_req(26'h3FF_FFFA, d, lat, st, rds);
    chk("wrap_do", d, 16'hFFFD);
    settle(10);
    chk("wrap_pf_addr", last_addr, 23'h0);
    chk("wrap_pf_cnt", rd_cnt - rds, 1);
    b = rd_cnt;
    do_req(26'h6, d, lat, st, rds);
    chk("wrap_hit_do", d, 16'h0003);
    chk("wrap_hit_lat", lat, 1);
    chk("wrap_hit_nrd", rds - b, 0);
    settle(10);

    // INV raised while the demand fetch is outstanding
    PF_EN = 1'b0;
    inv_pulse();
    ddr_lat = 5;
    b = rd_cnt;
    fork
      do_req(26'h20, d, lat, st, rds);
      begin
        wait_strobe(b);
        @(posedge CLK);
        #1 INV = 1'b1;
      end
    join
    INV = 1'b0;
    chk("inv_do", d, 16'h0010);
    b = rd_cnt;
    do_req(26'h20, d, lat, st, rds);
    chk("inv_miss_nrd", rds - b, 1);
    chk("inv_miss_do", d, 16'h0010);

    // DDR_BUSY held for ten cycles across a miss
    settle(3);
    ddr_lat  = 2;
    DDR_BUSY = 1'b1;
    fork
      do_req(26'h28, d, lat, st, rds);
      begin
        repeat (10) @(posedge CLK);
        #1 DDR_BUSY = 1'b0;
      end
    join
    chk("busy_strobe_lat", ddr_rd_cyc - st, 10);
    chk("busy_do", d, 16'h0014);

    // reset while the fetch is outstanding; late DDR_RDY must be ignored
    ddr_lat = 6;
    b = rd_cnt;
    REQ_A  = 25'h18;
    REQ_RD = 1'b1;
    wait_strobe(b);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    r0 = rdy_cnt;
    @(negedge CLK);
    chk("rstw_do", REQ_DO, 0);
    chk("rstw_rdy", REQ_RDY, 0);
    REQ_RD = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    settle(12);
    chk("rstw_late_rdy", rdy_cnt - r0, 0);
    b = rd_cnt;
    do_req(26'h30, d, lat, st, rds);
    chk("rstw_nrd", rds - b, 1);
    chk("rstw_do_after", d, 16'h0018);

    settle(5);
    chk("busy_violations", busy_viol, 0);
    chk("rdy_back_to_back", dbl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
